// File: rtl/bit_message_printer.sv
// Collects ASCII '0'/'1' bytes into a MSG_LEN-entry bit buffer and replays them to the UART tx.
// Optional CR/LF trailer after each message when BIT_MESSAGE_PRINTER_CRLF_EN is defined.
module bit_message_printer #(
  parameter int unsigned MSG_LEN    = 10,
  parameter int unsigned CNT_W      = 4,
  parameter logic [7:0]  FLUSH_CHAR = 8'h0D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             new_rx_data,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             new_tx_data,
  output logic [CNT_W-1:0] count,
  output logic             printing,
  output logic             overrun
);

  typedef enum logic [1:0] {COLLECT, PRINT, SEND, GAP} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] PTR_ONE  = CNT_W'(1);

  // Reset asserts asynchronously but releases two edges after rst_n rises.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  state_t             state, state_next;
  logic [CNT_W-1:0]   wr_ptr, rd_ptr;
  logic [MSG_LEN-1:0] buffer;
  logic               busy_q;
`ifdef BIT_MESSAGE_PRINTER_CRLF_EN
  logic [1:0]         trl_sent;
`endif

  logic       is_bit;
  logic       store_en;
  logic       load_en;
  logic       data_load;
  logic       clear_ptrs;
  logic [7:0] load_byte;

  assign is_bit = (rx_data == 8'h30) || (rx_data == 8'h31);

  // NOTE: every combinational output gets a default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    state_next = state;
    store_en   = 1'b0;
    load_en    = 1'b0;
    data_load  = 1'b0;
    clear_ptrs = 1'b0;
    load_byte  = tx_data;
    unique case (state)
      COLLECT: begin
        if (new_rx_data) begin
          if (is_bit) begin
            store_en = 1'b1;
            if (wr_ptr == LAST_IDX) state_next = PRINT;
          end else if (rx_data == FLUSH_CHAR && wr_ptr != '0) begin
            state_next = PRINT;
          end
        end
      end
      PRINT: begin
        if (rd_ptr != wr_ptr) begin
          if (!busy_q) begin
            load_en    = 1'b1;
            data_load  = 1'b1;
            load_byte  = {7'b0011000, buffer[rd_ptr]};
            state_next = SEND;
          end
`ifdef BIT_MESSAGE_PRINTER_CRLF_EN
        end else if (trl_sent != 2'd2) begin
          if (!busy_q) begin
            load_en    = 1'b1;
            load_byte  = (trl_sent == 2'd0) ? 8'h0D : 8'h0A;
            state_next = SEND;
          end
`endif
        end else begin
          clear_ptrs = 1'b1;
          state_next = COLLECT;
        end
      end
      SEND:    state_next = GAP;
      GAP:     state_next = PRINT;
      default: state_next = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= COLLECT;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      // NOTE: the bit buffer is only MSG_LEN flops, so it is cleared with the rest of the state.
      buffer      <= '0;
      busy_q      <= 1'b1;
      tx_data     <= 8'h00;
      new_tx_data <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      busy_q      <= tx_busy;
      new_tx_data <= load_en;
      overrun     <= new_rx_data && (state != COLLECT);
      if (store_en) begin
        buffer[wr_ptr] <= rx_data[0];
        wr_ptr         <= wr_ptr + PTR_ONE;
      end
      if (load_en) tx_data <= load_byte;
      if (data_load) rd_ptr <= rd_ptr + PTR_ONE;
      if (clear_ptrs) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
    end
  end

`ifdef BIT_MESSAGE_PRINTER_CRLF_EN
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)              trl_sent <= 2'd0;
    else if (clear_ptrs)         trl_sent <= 2'd0;
    else if (load_en && !data_load) trl_sent <= trl_sent + 2'd1;
  end
`endif

  assign printing = (state != COLLECT);
  assign count    = (state == COLLECT) ? wr_ptr : (wr_ptr - rd_ptr);

endmodule

// File: tb/tb_bit_message_printer.sv
// Self-checking bench for bit_message_printer: directed scenarios plus randomized messages
// checked against a queue-based model of the expected transmit stream.
module tb_bit_message_printer;

  localparam int         MSG_LEN = 10;
  localparam int         CNT_W   = 4;
  localparam logic [7:0] FLUSH   = 8'h0D;
`ifdef BIT_MESSAGE_PRINTER_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             new_rx_data = 1'b0;
  logic             tx_busy;
  logic [7:0]       tx_data;
  logic             new_tx_data;
  logic [CNT_W-1:0] count;
  logic             printing;
  logic             overrun;

  bit force_busy = 1'b0;
  bit model_busy = 1'b0;
  assign tx_busy = force_busy | model_busy;

  bit_message_printer #(.MSG_LEN(MSG_LEN), .CNT_W(CNT_W), .FLUSH_CHAR(FLUSH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_busy(tx_busy), .tx_data(tx_data), .new_tx_data(new_tx_data),
    .count(count), .printing(printing), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cnt;
    int         cyc;
  } strobe_t;

  int      n_cmp = 0;
  int      n_err = 0;
  int      cyc = 0;
  int      last_rx_cyc = 0;
  int      last_strobe = -100;
  int      ovr_cnt = 0;
  int      exp_ovr = 0;
  int      busy_left = 0;
  bit      rand_busy = 1'b0;
  strobe_t obs[$];
  bit      model_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor plus a simple tx model that holds busy for a random time after each strobe.
  always @(negedge clk) begin
    if (new_tx_data) begin
      check("busy_at_strobe", 32'(tx_busy), 32'd0);
      check("strobe_gap_min", 32'((cyc - last_strobe) >= 3), 32'd1);
      last_strobe = cyc;
      obs.push_back('{data: tx_data, cnt: int'(count), cyc: cyc});
      busy_left = rand_busy ? int'($urandom_range(0, 5)) : 0;
      model_busy = (busy_left > 0);
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) model_busy = 1'b0;
    end
    if (overrun) ovr_cnt++;
  end

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    new_rx_data = 1'b1;
    last_rx_cyc = cyc;
    @(posedge clk); #1;
    new_rx_data = 1'b0;
  endtask

  task automatic send_bit(input bit b);
    send_rx(8'h30 | 8'(b));
    model_q.push_back(b);
    check("count_collect", 32'(count), 32'(model_q.size()));
  endtask

  task automatic send_string(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_bit(s[i] == "1");
      repeat (gap) @(posedge clk);
    end
  endtask

  // Expected stream: each stored bit as '0'/'1' with remaining-count, then optional CR LF.
  task automatic expect_print(input int first_cyc, input bit exact);
    logic [7:0] exp_d[$];
    int         exp_c[$];
    int         len;
    int         budget;
    int         n;
    len = model_q.size();
    for (int i = 0; i < len; i++) begin
      exp_d.push_back(8'h30 | 8'(model_q[i]));
      exp_c.push_back(len - 1 - i);
    end
    if (CRLF) begin
      exp_d.push_back(8'h0D); exp_c.push_back(0);
      exp_d.push_back(8'h0A); exp_c.push_back(0);
    end
    budget = 3000;
    while (obs.size() < exp_d.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (10) @(negedge clk);
    check("strobe_total", 32'(obs.size()), 32'(exp_d.size()));
    n = (obs.size() < exp_d.size()) ? obs.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check("tx_data_seq", 32'(obs[i].data), 32'(exp_d[i]));
      check("count_print", 32'(obs[i].cnt), 32'(exp_c[i]));
      if (i == 0 && first_cyc >= 0) check("first_latency", 32'(obs[0].cyc), 32'(first_cyc));
      if (i > 0 && exact) check("strobe_spacing", 32'(obs[i].cyc - obs[i-1].cyc), 32'd3);
    end
    check("printing_after", 32'(printing), 32'd0);
    check("count_after", 32'(count), 32'd0);
    obs.delete();
    model_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         b_cyc;
    int         trig;
    int         len;
    logic [7:0] junk;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_new_tx", 32'(new_tx_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_printing", 32'(printing), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Full message, auto print, no busy
    send_string("1011001110", 19);
    trig = last_rx_cyc;
    expect_print(trig + 2, 1'b1);

    // Partial message flushed early
    send_string("01", 3);
    check("count_pre_flush", 32'(count), 32'd2);
    send_rx(FLUSH);
    expect_print(last_rx_cyc + 2, 1'b1);

    // Flush on empty buffer and ignored bytes
    send_rx(FLUSH);
    send_rx(8'h41);
    send_rx(8'h20);
    repeat (20) @(posedge clk);
    #1;
    check("empty_no_strobe", 32'(obs.size()), 32'd0);
    check("empty_count", 32'(count), 32'd0);
    check("empty_printing", 32'(printing), 32'd0);
    check("empty_overrun", 32'(ovr_cnt), 32'(exp_ovr));

    // Held busy, plus a byte received mid-print
    force_busy = 1'b1;
    send_string("0110100111", 1);
    trig = last_rx_cyc;
    repeat (5) @(posedge clk);
    send_rx(8'h31);
    exp_ovr++;
    while (cyc < trig + 50) @(posedge clk);
    #1;
    check("busy_no_strobe", 32'(obs.size()), 32'd0);
    check("busy_overrun", 32'(ovr_cnt), 32'(exp_ovr));
    @(posedge clk); #1;
    force_busy = 1'b0;
    b_cyc = cyc;
    expect_print(b_cyc + 2, 1'b1);

    // Reset asserted mid-print
    send_string("1100110011", 1);
    begin
      int budget = 500;
      while (obs.size() < 4 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    check("abort_reached", 32'(obs.size() >= 4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_new_tx", 32'(new_tx_data), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'h00);
    check("abort_printing", 32'(printing), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    obs.delete();
    model_q.delete();
    send_string("0", 2);
    send_rx(FLUSH);
    expect_print(last_rx_cyc + 2, 1'b1);

    // Single '1' then flush (trailer appended when CR/LF is enabled)
    send_string("1", 2);
    send_rx(FLUSH);
    expect_print(last_rx_cyc + 2, 1'b1);
    check("overrun_directed", 32'(ovr_cnt), 32'(exp_ovr));

    // Randomized messages with junk bytes, random tx busy and mid-print drops
    rand_busy = 1'b1;
    for (int m = 0; m < 14; m++) begin
      len = int'($urandom_range(1, MSG_LEN));
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          do junk = 8'($urandom); while (junk == 8'h30 || junk == 8'h31 || junk == FLUSH);
          send_rx(junk);
          check("count_junk", 32'(count), 32'(model_q.size()));
        end
        send_bit(1'($urandom));
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      if (len < MSG_LEN) send_rx(FLUSH);
      trig = last_rx_cyc;
      if ($urandom_range(0, 2) == 0) begin
        send_rx(8'h31);
        exp_ovr++;
      end
      expect_print(trig + 2, 1'b0);
      check("overrun_random", 32'(ovr_cnt), 32'(exp_ovr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
